// File: rtl/mem_subcycle_sequencer_pkg.sv
// rtl/mem_subcycle_sequencer_pkg.sv - shared types, constants and helpers for the memory subcycle sequencer
package mem_subcycle_sequencer_pkg;

   localparam int THREADS_PER_CORE = 4;
   localparam int NUM_LANES        = 16;

   typedef logic [$clog2(THREADS_PER_CORE)-1:0] thread_idx_t;
   typedef logic [$clog2(NUM_LANES)-1:0]        subcycle_t;

   // OR-reduction of set bit positions; exact for one-hot or all-zero inputs.
   function automatic logic [4:0] oh_to_idx(input logic [31:0] oh);
      logic [4:0] idx;
      idx = '0;
      for (int i = 0; i < 32; i++) begin
         if (oh[i]) idx = idx | 5'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/mem_subcycle_sequencer_rr_arbiter.sv
// rtl/mem_subcycle_sequencer_rr_arbiter.sv - round-robin arbiter with internal rotating priority pointer
module mem_subcycle_sequencer_rr_arbiter #(
   parameter int NUM_REQUESTERS = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQUESTERS-1:0] i_request,
   input  logic                      i_update,
   output logic [NUM_REQUESTERS-1:0] o_grant
);

   localparam int IW = $clog2(NUM_REQUESTERS);

   // r_ptr is the first requester searched; it moves to just past each winner.
   logic [IW-1:0] r_ptr;
   logic [IW-1:0] w_cand;
   logic [IW-1:0] w_idx;
   logic          w_found;

   always_comb begin
      o_grant = '0;
      w_found = 1'b0;
      w_idx   = r_ptr;
      w_cand  = r_ptr;
      for (int k = 0; k < NUM_REQUESTERS; k++) begin
         w_cand = r_ptr + IW'(k);
         if (!w_found && i_request[w_cand]) begin
            w_found = 1'b1;
            w_idx   = w_cand;
         end
      end
      if (w_found) o_grant[w_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ptr <= '0;
      end else if (i_update && w_found) begin
         r_ptr <= w_idx + 1'b1;
      end
   end

endmodule

// File: rtl/mem_subcycle_sequencer.sv
// rtl/mem_subcycle_sequencer.sv - thread arbiter and scatter/gather subcycle sequencer ahead of operand fetch
// Optional lane skipping over masked-off subcycles: MEM_SUBCYCLE_MASK_SKIP_EN.
module mem_subcycle_sequencer #(
   parameter int NUM_THREADS = mem_subcycle_sequencer_pkg::THREADS_PER_CORE,
   parameter int NUM_LANES   = mem_subcycle_sequencer_pkg::NUM_LANES
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_THREADS-1:0]           ts_request,
   input  logic [NUM_THREADS-1:0]           ts_is_scgath,
   input  logic [NUM_THREADS*NUM_LANES-1:0] ts_mask,
   input  logic [NUM_THREADS-1:0]           dd_thread_blocked,
   input  logic                             wb_rollback_en,
   input  logic [$clog2(NUM_THREADS)-1:0]   wb_rollback_thread_idx,
   input  logic [$clog2(NUM_LANES)-1:0]     wb_rollback_subcycle,
   output logic                             ms_issue_valid,
   output logic [$clog2(NUM_THREADS)-1:0]   ms_issue_thread_idx,
   output logic [$clog2(NUM_LANES)-1:0]     ms_issue_subcycle,
   output logic                             ms_issue_last,
   output logic [NUM_THREADS-1:0]           ms_thread_ack
);

   import mem_subcycle_sequencer_pkg::*;

   localparam int TW = $clog2(NUM_THREADS);
   localparam int SW = $clog2(NUM_LANES);

   logic [SW-1:0]          r_count [NUM_THREADS];
   logic [NUM_THREADS-1:0] w_elig;
   logic [NUM_THREADS-1:0] w_grant;
   logic [TW-1:0]          w_gidx;
   logic                   w_valid;
   logic [SW-1:0]          w_cnt;
   logic                   w_scgath;
   logic [NUM_LANES-1:0]   w_mask;
   logic [SW-1:0]          w_sg_sub;
   logic [SW-1:0]          w_sg_next;
   logic                   w_sg_last;
   logic [SW-1:0]          w_sub;
   logic                   w_last;

   // A thread being rolled back this cycle must not issue from a stale counter.
   always_comb begin
      w_elig = '0;
      for (int t = 0; t < NUM_THREADS; t++) begin
         w_elig[t] = ts_request[t] & ~dd_thread_blocked[t]
                   & ~(wb_rollback_en && (wb_rollback_thread_idx == TW'(t)));
      end
   end

   mem_subcycle_sequencer_rr_arbiter #(
      .NUM_REQUESTERS(NUM_THREADS)
   ) u_arbiter (
      .clk      (clk),
      .reset    (reset),
      .i_request(w_elig),
      .i_update (|w_elig),
      .o_grant  (w_grant)
   );

   assign w_valid  = |w_grant;
   assign w_gidx   = TW'(oh_to_idx(32'(w_grant)));
   assign w_cnt    = r_count[w_gidx];
   assign w_scgath = ts_is_scgath[w_gidx];
   assign w_mask   = ts_mask[w_gidx*NUM_LANES +: NUM_LANES];

`ifdef MEM_SUBCYCLE_MASK_SKIP_EN
   logic [SW-1:0] w_first;
   logic [SW-1:0] w_after;
   logic          w_has_first;
   logic          w_has_after;

   // Subcycle s maps to mask bit NUM_LANES-1-s; descending scans leave the lowest hit.
   always_comb begin
      w_first     = w_cnt;
      w_has_first = 1'b0;
      for (int s = NUM_LANES - 1; s >= 0; s--) begin
         if (SW'(s) >= w_cnt && w_mask[NUM_LANES-1-s]) begin
            w_first     = SW'(s);
            w_has_first = 1'b1;
         end
      end
      w_after     = '0;
      w_has_after = 1'b0;
      for (int s = NUM_LANES - 1; s >= 0; s--) begin
         if (SW'(s) > w_first && w_mask[NUM_LANES-1-s]) begin
            w_after     = SW'(s);
            w_has_after = 1'b1;
         end
      end
      w_sg_sub  = w_first;
      w_sg_last = !w_has_first || !w_has_after;
      w_sg_next = w_sg_last ? '0 : w_after;
   end
`else
   logic w_mask_unused;
   assign w_mask_unused = ^w_mask;

   always_comb begin
      w_sg_sub  = w_cnt;
      w_sg_last = (w_cnt == SW'(NUM_LANES - 1));
      w_sg_next = w_sg_last ? '0 : w_cnt + 1'b1;
   end
`endif

   assign w_sub  = w_scgath ? w_sg_sub : '0;
   assign w_last = w_scgath ? w_sg_last : 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ms_issue_valid      <= 1'b0;
         ms_issue_thread_idx <= '0;
         ms_issue_subcycle   <= '0;
         ms_issue_last       <= 1'b0;
         ms_thread_ack       <= '0;
         for (int t = 0; t < NUM_THREADS; t++) r_count[t] <= '0;
      end else begin
         ms_issue_valid      <= w_valid;
         ms_issue_thread_idx <= w_valid ? w_gidx : '0;
         ms_issue_subcycle   <= w_valid ? w_sub : '0;
         ms_issue_last       <= w_valid & w_last;
         ms_thread_ack       <= (w_valid && w_last) ? w_grant : '0;
         for (int t = 0; t < NUM_THREADS; t++) begin
            if (wb_rollback_en && wb_rollback_thread_idx == TW'(t)) begin
               r_count[t] <= wb_rollback_subcycle;
            end else if (w_grant[t] && w_scgath) begin
               r_count[t] <= w_sg_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_subcycle_sequencer.sv
// tb/tb_mem_subcycle_sequencer.sv - scoreboard bench for mem_subcycle_sequencer
module tb_mem_subcycle_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  ts_request;
   logic [3:0]  ts_is_scgath;
   logic [63:0] ts_mask;
   logic [3:0]  dd_thread_blocked;
   logic        wb_rollback_en;
   logic [1:0]  wb_rollback_thread_idx;
   logic [3:0]  wb_rollback_subcycle;
   logic        ms_issue_valid;
   logic [1:0]  ms_issue_thread_idx;
   logic [3:0]  ms_issue_subcycle;
   logic        ms_issue_last;
   logic [3:0]  ms_thread_ack;

   always #5 clk = ~clk;

   mem_subcycle_sequencer #(
      .NUM_THREADS(4),
      .NUM_LANES  (16)
   ) dut (
      .clk                   (clk),
      .reset                 (reset),
      .ts_request            (ts_request),
      .ts_is_scgath          (ts_is_scgath),
      .ts_mask               (ts_mask),
      .dd_thread_blocked     (dd_thread_blocked),
      .wb_rollback_en        (wb_rollback_en),
      .wb_rollback_thread_idx(wb_rollback_thread_idx),
      .wb_rollback_subcycle  (wb_rollback_subcycle),
      .ms_issue_valid        (ms_issue_valid),
      .ms_issue_thread_idx   (ms_issue_thread_idx),
      .ms_issue_subcycle     (ms_issue_subcycle),
      .ms_issue_last         (ms_issue_last),
      .ms_thread_ack         (ms_thread_ack)
   );

   typedef struct packed {
      logic [1:0] t;
      logic [3:0] s;
      logic       l;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_issue(input int t, input int s, input int l);
      exp_t e;
      e.t = 2'(t);
      e.s = 4'(s);
      e.l = (l != 0);
      exp_q.push_back(e);
   endtask

   task automatic drain(input string name);
      repeat (3) step();
      chk(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic idle_inputs();
      ts_request             = '0;
      ts_is_scgath           = '0;
      ts_mask                = '1;
      dd_thread_blocked      = '0;
      wb_rollback_en         = 1'b0;
      wb_rollback_thread_idx = '0;
      wb_rollback_subcycle   = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
   endtask

   task automatic chk_outputs_zero(input string name);
      chk({name, "_valid"}, ms_issue_valid, 0);
      chk({name, "_tidx"},  ms_issue_thread_idx, 0);
      chk({name, "_sub"},   ms_issue_subcycle, 0);
      chk({name, "_last"},  ms_issue_last, 0);
      chk({name, "_ack"},   ms_thread_ack, 0);
   endtask

   // Monitor: every presented issue must match the head of the expectation queue.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (ms_issue_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_issue: got thread %0d sub %0d last %0d, required no issue",
                        ms_issue_thread_idx, ms_issue_subcycle, ms_issue_last);
            end else begin
               mon_e = exp_q.pop_front();
               chk("issue_thread", ms_issue_thread_idx, mon_e.t);
               chk("issue_sub", ms_issue_subcycle, mon_e.s);
               chk("issue_last", ms_issue_last, mon_e.l);
               chk("issue_ack", ms_thread_ack, mon_e.l ? (32'd1 << mon_e.t) : 32'd0);
            end
         end else begin
            chk("idle_ack", ms_thread_ack, 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   initial begin
      idle_inputs();
      reset = 1'b0;
      step();
      step();
      chk_outputs_zero("reset");
      reset = 1'b1;
      step();

      // Single-thread gather walks 0..15, then restarts at 0.
      ts_request   = 4'b0001;
      ts_is_scgath = 4'b0001;
      for (int s = 0; s < 16; s++) begin
         expect_issue(0, s, s == 15);
         step();
      end
      expect_issue(0, 0, 0);
      step();
      ts_request = '0;
      drain("gather16_drain");
      do_reset();

      // Scalar round robin over all four threads.
      ts_request = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         expect_issue(i % 4, 0, 1);
         step();
      end
      ts_request = '0;
      drain("rr_drain");
      do_reset();

      // Rollback of thread 1 while thread 0 wins the same cycle.
      ts_request   = 4'b0010;
      ts_is_scgath = 4'b0010;
      for (int s = 0; s < 5; s++) begin
         expect_issue(1, s, 0);
         step();
      end
      ts_request             = 4'b0011;
      wb_rollback_en         = 1'b1;
      wb_rollback_thread_idx = 2'd1;
      wb_rollback_subcycle   = 4'd3;
      expect_issue(0, 0, 1);
      step();
      wb_rollback_en = 1'b0;
      ts_request     = 4'b0010;
      expect_issue(1, 3, 0);
      step();
      expect_issue(1, 4, 0);
      step();
      ts_request = '0;
      drain("rollback_drain");
      do_reset();

      // Blocked thread 2 keeps its place while thread 3 is served.
      ts_request   = 4'b0100;
      ts_is_scgath = 4'b0100;
      for (int s = 0; s < 7; s++) begin
         expect_issue(2, s, 0);
         step();
      end
      dd_thread_blocked = 4'b0100;
      ts_request        = 4'b1100;
      for (int i = 0; i < 10; i++) begin
         expect_issue(3, 0, 1);
         step();
      end
      dd_thread_blocked = '0;
      ts_request        = 4'b0100;
      expect_issue(2, 7, 0);
      step();
      ts_request = '0;
      drain("blocked_drain");
      do_reset();

      // Asynchronous reset mid-gather clears outputs and the counter.
      ts_request   = 4'b0001;
      ts_is_scgath = 4'b0001;
      for (int s = 0; s < 9; s++) begin
         expect_issue(0, s, 0);
         step();
      end
      @(negedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk_outputs_zero("async_reset");
      step();
      reset = 1'b1;
      expect_issue(0, 0, 0);
      step();
      expect_issue(0, 1, 0);
      step();
      ts_request = '0;
      drain("after_reset_drain");
      do_reset();

      // Sparse mask on thread 0.
      ts_request    = 4'b0001;
      ts_is_scgath  = 4'b0001;
      ts_mask[15:0] = 16'h8001;
`ifdef MEM_SUBCYCLE_MASK_SKIP_EN
      expect_issue(0, 0, 0);
      step();
      expect_issue(0, 15, 1);
      step();
      ts_mask[15:0] = 16'h0000;
      expect_issue(0, 0, 1);
      step();
`else
      for (int s = 0; s < 16; s++) begin
         expect_issue(0, s, s == 15);
         step();
      end
`endif
      ts_request = '0;
      drain("mask_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
